// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// No logic of its own; imported by the loader, packer and interface users.
// Holds the FSM encoding and the word/address geometry.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WORD_BYTES    = 4;
  localparam int MEM_DEPTH_DEF = 32;
  // Word index to byte address: addr = idx << ADDR_SHIFT.
  localparam int ADDR_SHIFT    = 2;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input plus instruction-memory write port of the loader.
// Pure wiring, no latency.
// byte_ready_o is the only backpressure signal; the write port has none.
interface instr_mem_loader_if;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;

  // Loader side: consumes bytes, drives memory writes.
  modport master (
    input  byte_i, byte_valid_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );

  // Environment side: byte source and instruction memory.
  modport slave (
    output byte_i, byte_valid_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/instr_byte_packer.sv
// Big-endian byte-to-word packer: first byte ends up in [31:24].
// word_full_o is combinational on the shift that completes a word.
// No backpressure of its own; the caller decides when to shift.
module instr_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]  r_cnt;
  logic [31:0] r_shift;

  // Shift bytes in from the bottom; clear wins over a same-cycle shift.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt   <= 2'd0;
      r_shift <= 32'd0;
    end else if (shift_i) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {r_shift[23:0], byte_i};
    end
  end

  assign word_o      = r_shift;
  assign word_full_o = shift_i && (r_cnt == LAST_IDX);

endmodule

// File: rtl/instr_mem_loader.sv
// Packs a byte stream into 32-bit words and writes them to addr 0,4,8,...
// 4th byte accepted at edge N -> wr_en_o high in cycle N+1; 5 cycles/word min.
// byte_ready_o is high only in LOAD; it drops for the WRITE cycle of each word.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int CNT_W     = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] len_i,
  instr_mem_loader_if.master mem_bus,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] wr_count_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MEM_DEPTH);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_len, r_word_cnt, r_wr_count;
  logic [CNT_W-1:0] w_len_eff, w_cnt_inc;
  logic [31:0]      r_addr_hold, r_data_hold;
  logic [31:0]      w_word, w_addr;
  logic             w_start, w_shift, w_word_full, w_pk_clr, w_wr;

  // Zero and out-of-range lengths both mean a full memory image.
  assign w_len_eff = ((len_i == '0) || (len_i > DEPTH_C)) ? DEPTH_C : len_i;
  assign w_start   = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_shift   = (r_state == ST_LOAD) && mem_bus.byte_valid_i;
  assign w_wr      = (r_state == ST_WRITE) && !abort_i;
  assign w_cnt_inc = r_word_cnt + CNT_W'(1);
  assign w_addr    = 32'(r_word_cnt) << ADDR_SHIFT;

  instr_byte_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (w_pk_clr),
    .shift_i     (w_shift),
    .byte_i      (mem_bus.byte_i),
    .word_o      (w_word),
    .word_full_o (w_word_full)
  );

  // Next state; the packer is flushed on start, abort and after each write.
  always_comb begin
    w_next   = r_state;
    w_pk_clr = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_next   = ST_LOAD;
          w_pk_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort_i) begin
          w_next   = ST_IDLE;
          w_pk_clr = 1'b1;
        end else if (w_word_full) begin
          w_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_pk_clr = 1'b1;
        if (abort_i)                 w_next = ST_IDLE;
        else if (w_cnt_inc == r_len) w_next = ST_DONE;
        else                         w_next = ST_LOAD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, length/word counters and the held address/data of the last write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_wr_count  <= '0;
      r_addr_hold <= 32'd0;
      r_data_hold <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_len      <= w_len_eff;
        r_word_cnt <= '0;
        r_wr_count <= '0;
      end
      if (w_wr) begin
        r_word_cnt  <= w_cnt_inc;
        r_wr_count  <= w_cnt_inc;
        r_addr_hold <= w_addr;
        r_data_hold <= w_word;
      end
    end
  end

  assign mem_bus.byte_ready_o = (r_state == ST_LOAD);
  assign mem_bus.wr_en_o      = w_wr;
  assign mem_bus.wr_addr_o    = w_wr ? w_addr : r_addr_hold;
  assign mem_bus.wr_data_o    = w_wr ? w_word : r_data_hold;
  assign busy_o               = (r_state == ST_LOAD) || (r_state == ST_WRITE);
  assign done_o               = (r_state == ST_DONE);
  assign wr_count_o           = r_wr_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboarded bench for instr_mem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every wr_en_o pulse.
// Directed checks cover reset, done/busy/count, abort and ignored inputs.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] len = 6'd0;
  logic       busy, done;
  logic [5:0] wr_count;

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_writes = 0;
  int          cyc = 0;
  logic [31:0] last_addr = 32'd0;
  wr_t         exp_q[$];

  instr_mem_loader_if bus ();

  instr_mem_loader #(.MEM_DEPTH(32), .CNT_W(6)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .len_i      (len),
    .mem_bus    (bus.master),
    .busy_o     (busy),
    .done_o     (done),
    .wr_count_o (wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (bus.wr_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                 bus.wr_addr_o, bus.wr_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.wr_addr_o, e.addr);
        chk("wr_data", bus.wr_data_o, e.data);
      end
      chk("ready_low_in_write", 32'(bus.byte_ready_o), 32'd0);
      last_addr = bus.wr_addr_o;
      n_writes++;
    end
  end

  // Called just after a posedge; returns just after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    int budget;
    bit ok;
    budget = 200;
    ok = 1'b0;
    bus.byte_i = b;
    bus.byte_valid_i = 1'b1;
    while (!ok && budget > 0) begin
      @(negedge clk);
      if (bus.byte_ready_o === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
      budget--;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL byte_timeout: byte 0x%02h never accepted, expected acceptance", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          bus.byte_valid_i = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      send_byte(w[31 - 8*i -: 8]);
    end
  endtask

  task automatic do_start(input logic [5:0] l);
    start = 1'b1;
    len = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int budget;
    budget = 300;
    while (done !== 1'b1 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready_o), 32'd0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en_o), 32'd0);
    chk({tag, "_addr"}, bus.wr_addr_o, 32'd0);
    chk({tag, "_data"}, bus.wr_data_o, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_count"}, 32'(wr_count), 32'd0);
  endtask

  initial begin
    int t0, td;
    logic [31:0] w;
    bus.byte_i = 8'd0;
    bus.byte_valid_i = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // 1: single word, back-to-back bytes
    do_start(6'd1);
    push_wr(32'h0, 32'h20010005);
    send_word(32'h20010005, 1'b0);
    bus.byte_valid_i = 1'b0;
    chk("t1_wr_en_latency", 32'(bus.wr_en_o), 32'd1);
    @(posedge clk);
    #1;
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_count", 32'(wr_count), 32'd1);
    chk("t1_writes", n_writes, 1);

    // 2: three words with random valid gaps
    do_start(6'd3);
    push_wr(32'h0, 32'h11223344);
    push_wr(32'h4, 32'hAABBCCDD);
    push_wr(32'h8, 32'h01020304);
    send_word(32'h11223344, 1'b1);
    send_word(32'hAABBCCDD, 1'b1);
    send_word(32'h01020304, 1'b1);
    bus.byte_valid_i = 1'b0;
    wait_done("t2_done");
    chk("t2_count", 32'(wr_count), 32'd3);

    // 3: len 0 means full depth; 128-byte continuous stream
    do_start(6'd0);
    for (int k = 0; k < 32; k++) begin
      w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      push_wr(32'(4*k), w);
    end
    t0 = 0;
    for (int i = 0; i < 128; i++) begin
      send_byte(8'(i));
      if (i == 0) t0 = cyc;
    end
    bus.byte_valid_i = 1'b0;
    wait_done("t3_done");
    td = cyc;
    // 32 words x 5 edges: counting the edge that took the first byte as
    // edge 1, the last WRITE closes on edge 160, i.e. 159 edges later.
    chk("t3_done_latency", td - t0, 159);
    chk("t3_count", 32'(wr_count), 32'd32);
    chk("t3_last_addr", last_addr, 32'h7C);

    // 4: abort mid-word, then a fresh load must not see the stale bytes
    do_start(6'd4);
    push_wr(32'h0, 32'hDEADBEEF);
    send_word(32'hDEADBEEF, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    bus.byte_valid_i = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ready", 32'(bus.byte_ready_o), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_count", 32'(wr_count), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    do_start(6'd1);
    push_wr(32'h0, 32'h0A0B0C0D);
    send_word(32'h0A0B0C0D, 1'b0);
    bus.byte_valid_i = 1'b0;
    wait_done("t4_reload_done");
    chk("t4_reload_count", 32'(wr_count), 32'd1);

    // 5: reset on the edge that would take the 4th byte
    do_start(6'd1);
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h43);
    bus.byte_i = 8'h44;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("t5");
    rst = 1'b0;
    bus.byte_valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_no_write", 32'(bus.wr_en_o), 32'd0);

    // 6: bytes in IDLE are refused; start mid-load is ignored
    bus.byte_i = 8'hFF;
    bus.byte_valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t6_idle_ready", 32'(bus.byte_ready_o), 32'd0);
    end
    bus.byte_valid_i = 1'b0;
    do_start(6'd2);
    push_wr(32'h0, 32'h13579BDF);
    push_wr(32'h4, 32'h2468ACE0);
    send_byte(8'h13);
    send_byte(8'h57);
    bus.byte_valid_i = 1'b0;
    do_start(6'd5);
    chk("t6_busy_after_restart", 32'(busy), 32'd1);
    send_byte(8'h9B);
    send_byte(8'hDF);
    send_word(32'h2468ACE0, 1'b0);
    bus.byte_valid_i = 1'b0;
    wait_done("t6_done");
    chk("t6_count", 32'(wr_count), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
